// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR definitions for the csr block and its counter unit.
//   - 12-bit CSR addresses for the machine counters, mcountinhibit and the
//     read-only user aliases.
//   - mcountinhibit bit indices (CY, IR) and the implemented-bit mask.
//   - Counter slot indices used by csr_counters.
package csr_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  localparam int CNT_CY = 0;
  localparam int CNT_IR = 2;

  // Only CY and IR exist; every other mcountinhibit bit is hardwired to 0.
  localparam logic [31:0] CNT_INHIBIT_MASK = (32'd1 << CNT_CY) | (32'd1 << CNT_IR);

  // Counter slots inside csr_counters.
  localparam int NUM_CNT     = 2;
  localparam int CNT_IDX_CYC = 0;
  localparam int CNT_IDX_RET = 1;

  // True for the 0xB00-0xB9F machine counter window or the 0xC00-0xC9F
  // user counter window, given the high nibble to test against.
  function automatic logic in_counter_window(logic [11:0] addr, logic [3:0] nibble);
    return (addr[11:8] == nibble) && (addr[7:0] < 8'hA0);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with independently writable 32-bit halves.
//   clk, rst : clock, asynchronous active-high reset (loads RESET_VALUE)
//   inc      : add one at the next edge
//   we_lo    : replace bits [31:0] with wdata
//   we_hi    : replace bits [63:32] with wdata
//   wdata    : 32-bit write data
//   q        : current counter value
// A write to either half suppresses the increment for that edge, so the
// written value is exactly what reads back next cycle.
module csr_counter64 #(
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  logic [63:0] q_reg;
  logic [63:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (we_lo || we_hi) begin
      if (we_lo) q_next[31:0]  = wdata;
      if (we_hi) q_next[63:32] = wdata;
    end else if (inc) begin
      q_next = q_reg + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_reg <= RESET_VALUE;
    else     q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/csr_counters.sv
// csr_counters: machine-mode performance counters (mcycle, minstret) and
// mcountinhibit, answering CSR accesses on behalf of the csr block.
//   clk, rst    : clock, asynchronous active-high reset
//   retire      : one instruction retires this cycle
//   csr_addr    : CSR address of the current instruction
//   csr_we      : write strobe (already qualified upstream)
//   csr_wdata   : final write value (set/clear already resolved)
//   csr_rdata   : read data for csr_addr, 0 when not ours (combinational)
//   csr_hit     : csr_addr is one of the nine addresses owned here
//   csr_illegal : write to a read-only or unimplemented address in the
//                 0xB00-0xB9F / 0xC00-0xC9F windows (combinational)
module csr_counters
  import csr_pkg::*;
#(
  parameter logic [63:0] RESET_CYCLE   = 64'd0,
  parameter logic [63:0] RESET_INSTRET = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        csr_illegal
);

  logic [31:0] mcountinhibit_reg;
  logic [31:0] mcountinhibit_next;

  logic [NUM_CNT-1:0] cnt_inc;
  logic [NUM_CNT-1:0] cnt_we_lo;
  logic [NUM_CNT-1:0] cnt_we_hi;
  logic [63:0]        cnt_q [NUM_CNT];

  // Both counters share one structure; only the reset value, the CSR
  // addresses, the inhibit bit and the count event differ per slot.
  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      localparam logic [63:0] RST_VAL = (gi == CNT_IDX_CYC) ? RESET_CYCLE : RESET_INSTRET;
      localparam logic [11:0] ADDR_LO = (gi == CNT_IDX_CYC) ? CSR_MCYCLE  : CSR_MINSTRET;
      localparam logic [11:0] ADDR_HI = (gi == CNT_IDX_CYC) ? CSR_MCYCLEH : CSR_MINSTRETH;
      localparam int          INH_BIT = (gi == CNT_IDX_CYC) ? CNT_CY      : CNT_IR;

      logic event_hit;
      assign event_hit = (gi == CNT_IDX_CYC) ? 1'b1 : retire;

      // The current (pre-edge) inhibit bit is used, so a write to
      // mcountinhibit only affects counting from the following cycle.
      assign cnt_inc[gi]   = event_hit && !mcountinhibit_reg[INH_BIT];
      assign cnt_we_lo[gi] = csr_we && (csr_addr == ADDR_LO);
      assign cnt_we_hi[gi] = csr_we && (csr_addr == ADDR_HI);

      csr_counter64 #(
        .RESET_VALUE(RST_VAL)
      ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc[gi]),
        .we_lo(cnt_we_lo[gi]),
        .we_hi(cnt_we_hi[gi]),
        .wdata(csr_wdata),
        .q    (cnt_q[gi])
      );
    end
  endgenerate

  always_comb begin
    mcountinhibit_next = mcountinhibit_reg;
    if (csr_we && (csr_addr == CSR_MCOUNTINHIBIT))
      mcountinhibit_next = csr_wdata & CNT_INHIBIT_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcountinhibit_reg <= 32'd0;
    else     mcountinhibit_reg <= mcountinhibit_next;
  end

  // Read mux: user aliases return the same halves as the machine CSRs.
  always_comb begin
    csr_rdata = 32'd0;
    csr_hit   = 1'b1;
    case (csr_addr)
      CSR_MCYCLE,    CSR_CYCLE:    csr_rdata = cnt_q[CNT_IDX_CYC][31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   csr_rdata = cnt_q[CNT_IDX_CYC][63:32];
      CSR_MINSTRET,  CSR_INSTRET:  csr_rdata = cnt_q[CNT_IDX_RET][31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = cnt_q[CNT_IDX_RET][63:32];
      CSR_MCOUNTINHIBIT:           csr_rdata = mcountinhibit_reg;
      default:                     csr_hit   = 1'b0;
    endcase
  end

  // The whole user window is read-only; in the machine window only the
  // four implemented counter halves accept writes. Illegal writes never
  // match a counter write enable, so they leave all state untouched.
  assign csr_illegal = csr_we &&
                       (in_counter_window(csr_addr, 4'hC) ||
                        (in_counter_window(csr_addr, 4'hB) && !csr_hit));

endmodule
